seq_muldiv_unit: RTL and testbench

//  Parametrised multi-cycle multiply/divide coprocessor for the 8-bit CPU datapath, replacing the combinational MUL/DIV ALU ops.

---
 rtl/seq_muldiv_unit_if.sv | 32 +++
 rtl/seq_muldiv_unit.sv | 180 ++++++++++++++++++
 tb/tb_seq_muldiv_unit.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/seq_muldiv_unit_if.sv
// seq_muldiv_unit_if: issue/result bundle between the core decoder and the
// multi-cycle multiply/divide unit.
//
// Handshake: the master raises start with op/sgn/a/b valid; the unit takes
// them on a rising edge where busy==0 and ignores start while busy==1.
// done is a one-cycle pulse, and res_lo/res_hi/flag_c/flag_dz are valid in
// that cycle. The result registers keep their values until the next done.
interface seq_muldiv_unit_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             op;
    logic             sgn;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] res_lo;
    logic [WIDTH-1:0] res_hi;
    logic             flag_c;
    logic             flag_dz;

    modport master (
        output start, op, sgn, a, b,
        input  busy, done, res_lo, res_hi, flag_c, flag_dz
    );

    modport slave (
        input  start, op, sgn, a, b,
        output busy, done, res_lo, res_hi, flag_c, flag_dz
    );
endinterface

// File: rtl/seq_muldiv_unit.sv
// seq_muldiv_unit: sequential multiply (shift-add) and divide (restoring).
// The unit handles one bit per clock and uses a start/busy/done handshake.
// Optional feature macro: MULDIV_SIGNED_EN. When it is defined, sgn=1 selects
// signed operands: magnitudes are taken at capture and the result signs are
// fixed on entry to DONE. When it is undefined, sgn is ignored.
module seq_muldiv_unit #(
    parameter int WIDTH     = 8,
    parameter bit FAST_ZERO = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    seq_muldiv_unit_if.slave   bus,
    output logic [1:0]         dbg_state_o
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] acc_q;     // mul: {partial high, multiplier}; div: {remainder, dividend/quotient}
    logic [WIDTH-1:0]   opb_q;     // multiplicand or divisor magnitude
    logic               op_q;
    logic               busy_q, done_q, flag_c_q, flag_dz_q;
    logic [WIDTH-1:0]   res_lo_q, res_hi_q;

    logic [WIDTH-1:0]   mag_a, mag_b;
    logic               fast_c;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   diff;
    logic               ge;
    logic [2*WIDTH-1:0] acc_nx;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem;
    logic [WIDTH-1:0]   fin_lo, fin_hi;
    logic               fin_c;

`ifdef MULDIV_SIGNED_EN
    logic sgn_q, neg_lo_q, neg_hi_q, ovf_q;
    logic neg_lo_c, neg_hi_c, ovf_c;

    // Operand magnitudes and sign bookkeeping at the capture edge
    always_comb begin
        mag_a    = (bus.sgn && bus.a[WIDTH-1]) ? (-bus.a) : bus.a;
        mag_b    = (bus.sgn && bus.b[WIDTH-1]) ? (-bus.b) : bus.b;
        neg_lo_c = bus.sgn && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
        neg_hi_c = bus.sgn && bus.a[WIDTH-1];
        ovf_c    = bus.sgn && bus.op && (bus.a == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.b == '1);
    end
`else
    logic unused_sgn;
    assign unused_sgn = bus.sgn;

    // Unsigned-only build: operands pass straight through
    always_comb begin
        mag_a = bus.a;
        mag_b = bus.b;
    end
`endif

    // The fast path finishes in one edge: divide by zero always, and a zero multiply operand when FAST_ZERO=1
    always_comb begin
        fast_c = bus.op ? (bus.b == '0) : (FAST_ZERO && ((bus.a == '0) || (bus.b == '0)));
    end

    // One iteration of the datapath, plus the results that load on entry to DONE
    always_comb begin
        sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        trial  = acc_q[2*WIDTH-1:WIDTH-1];
        ge     = (trial >= {1'b0, opb_q});
        diff   = trial[WIDTH-1:0] - opb_q;
        acc_nx = op_q ? {(ge ? diff : trial[WIDTH-1:0]), acc_q[WIDTH-2:0], ge}
                      : {sum, acc_q[WIDTH-1:1]};
        prod   = acc_nx;
        quo    = acc_nx[WIDTH-1:0];
        rem    = acc_nx[2*WIDTH-1:WIDTH];
`ifdef MULDIV_SIGNED_EN
        if (neg_lo_q) prod = -acc_nx;
        if (neg_lo_q) quo  = -acc_nx[WIDTH-1:0];
        if (neg_hi_q) rem  = -acc_nx[2*WIDTH-1:WIDTH];
`endif
        if (op_q) begin
            fin_lo = quo;
            fin_hi = rem;
            fin_c  = (rem != '0);
`ifdef MULDIV_SIGNED_EN
            fin_c  = fin_c || ovf_q;
`endif
        end else begin
            fin_lo = prod[WIDTH-1:0];
            fin_hi = prod[2*WIDTH-1:WIDTH];
            fin_c  = (fin_hi != '0);
`ifdef MULDIV_SIGNED_EN
            if (sgn_q) fin_c = (fin_hi != {WIDTH{fin_lo[WIDTH-1]}});
`endif
        end
    end

    // Control FSM with registered handshake outputs and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opb_q     <= '0;
            op_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            flag_c_q  <= 1'b0;
            flag_dz_q <= 1'b0;
            res_lo_q  <= '0;
            res_hi_q  <= '0;
`ifdef MULDIV_SIGNED_EN
            sgn_q     <= 1'b0;
            neg_lo_q  <= 1'b0;
            neg_hi_q  <= 1'b0;
            ovf_q     <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        op_q  <= bus.op;
                        opb_q <= bus.op ? mag_b : mag_a;
                        acc_q <= {{WIDTH{1'b0}}, (bus.op ? mag_a : mag_b)};
`ifdef MULDIV_SIGNED_EN
                        sgn_q    <= bus.sgn;
                        neg_lo_q <= neg_lo_c;
                        neg_hi_q <= neg_hi_c;
                        ovf_q    <= ovf_c;
`endif
                        if (fast_c) begin
                            state_q   <= S_DONE;
                            done_q    <= 1'b1;
                            res_lo_q  <= bus.op ? '1 : '0;
                            res_hi_q  <= bus.op ? bus.a : '0;
                            flag_c_q  <= bus.op;
                            flag_dz_q <= bus.op;
                        end else begin
                            state_q <= S_RUN;
                            busy_q  <= 1'b1;
                            cnt_q   <= CW'(WIDTH);
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    // When the counter reaches zero on this edge, it was the last iteration
                    acc_q <= acc_nx;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q   <= S_DONE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        res_lo_q  <= fin_lo;
                        res_hi_q  <= fin_hi;
                        flag_c_q  <= fin_c;
                        flag_dz_q <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.res_lo  = res_lo_q;
    assign bus.res_hi  = res_hi_q;
    assign bus.flag_c  = flag_c_q;
    assign bus.flag_dz = flag_dz_q;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_seq_muldiv_unit.sv
// tb_seq_muldiv_unit: directed checks of seq_muldiv_unit (WIDTH=8, FAST_ZERO=1).
// Latency is counted in edges after the accepting edge: 8 for the normal path,
// which puts done 9 cycles after the start cycle, and 0 for the fast path.
module tb_seq_muldiv_unit;
    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;
    int         n_checks = 0;
    int         n_fail   = 0;
    int         lat;
    int         done_seen;

    seq_muldiv_unit_if #(.WIDTH(8)) bus ();

    seq_muldiv_unit #(.WIDTH(8), .FAST_ZERO(1'b1)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic issue(input logic op_v, input logic sgn_v, input logic [7:0] a_v, input logic [7:0] b_v);
        bus.start = 1'b1;
        bus.op    = op_v;
        bus.sgn   = sgn_v;
        bus.a     = a_v;
        bus.b     = b_v;
        step();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int l);
        l = 0;
        while (bus.done !== 1'b1 && l < 40) begin
            step();
            l++;
        end
    endtask

    task automatic check_res(input string tag, input logic [7:0] lo, input logic [7:0] hi,
                             input logic c, input logic dz);
        check({tag, " res_lo"},  {24'h0, bus.res_lo}, {24'h0, lo});
        check({tag, " res_hi"},  {24'h0, bus.res_hi}, {24'h0, hi});
        check({tag, " flag_c"},  {31'h0, bus.flag_c}, {31'h0, c});
        check({tag, " flag_dz"}, {31'h0, bus.flag_dz}, {31'h0, dz});
    endtask

    task automatic run_op(input string tag, input logic op_v, input logic sgn_v,
                          input logic [7:0] a_v, input logic [7:0] b_v, input int exp_lat,
                          input logic [7:0] lo, input logic [7:0] hi, input logic c, input logic dz);
        int l;
        issue(op_v, sgn_v, a_v, b_v);
        check({tag, " busy"}, {31'h0, bus.busy}, (exp_lat != 0) ? 32'd1 : 32'd0);
        wait_done(l);
        check({tag, " latency"}, l, exp_lat);
        check_res(tag, lo, hi, c, dz);
        step();
        check({tag, " done pulse"}, {31'h0, bus.done}, 32'd0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.op    = 1'b0;
        bus.sgn   = 1'b0;
        bus.a     = 8'h00;
        bus.b     = 8'h00;
        rst       = 1'b1;
        step();
        step();
        check("reset busy",  {31'h0, bus.busy}, 32'd0);
        check("reset done",  {31'h0, bus.done}, 32'd0);
        check("reset state", {30'h0, dbg_state}, 32'd0);
        check_res("reset", 8'h00, 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
        step();

        run_op("mul 200*3",   1'b0, 1'b0, 8'd200, 8'd3,  8, 8'h58, 8'h02, 1'b1, 1'b0);
        check("hold in idle", {24'h0, bus.res_lo}, 32'h58);
        run_op("div 100/7",   1'b1, 1'b0, 8'd100, 8'd7,  8, 8'h0E, 8'h02, 1'b1, 1'b0);
        run_op("div 80/10",   1'b1, 1'b0, 8'h80,  8'h10, 8, 8'h08, 8'h00, 1'b0, 1'b0);
        run_op("div 55/0",    1'b1, 1'b0, 8'h55,  8'h00, 0, 8'hFF, 8'h55, 1'b1, 1'b1);
        run_op("mul 00*37",   1'b0, 1'b0, 8'h00,  8'h37, 0, 8'h00, 8'h00, 1'b0, 1'b0);
        run_op("mul FF*FF",   1'b0, 1'b0, 8'hFF,  8'hFF, 8, 8'h01, 8'hFE, 1'b1, 1'b0);
        run_op("div FF/01",   1'b1, 1'b0, 8'hFF,  8'h01, 8, 8'hFF, 8'h00, 1'b0, 1'b0);
        run_op("div 07/09",   1'b1, 1'b0, 8'h07,  8'h09, 8, 8'h00, 8'h07, 1'b1, 1'b0);

        // A start pulse during RUN with different operands must be dropped
        issue(1'b0, 1'b0, 8'd13, 8'd11);
        check("midrun state", {30'h0, dbg_state}, 32'd1);
        issue(1'b1, 1'b0, 8'hFF, 8'hFF);
        step();
        wait_done(lat);
        check("midrun latency", lat + 2, 8);
        check_res("midrun 13*11", 8'h8F, 8'h00, 1'b0, 1'b0);

        // Back-to-back: start held during the DONE cycle
        issue(1'b0, 1'b0, 8'd5, 8'd6);
        wait_done(lat);
        check("b2b first latency", lat, 8);
        check_res("b2b 5*6", 8'h1E, 8'h00, 1'b0, 1'b0);
        issue(1'b1, 1'b0, 8'hC8, 8'h0A);
        check("b2b second busy", {31'h0, bus.busy}, 32'd1);
        check("b2b second done", {31'h0, bus.done}, 32'd0);
        wait_done(lat);
        check("b2b second latency", lat, 8);
        check_res("b2b C8/0A", 8'h14, 8'h00, 1'b0, 1'b0);
        step();

        // Reset in the fourth RUN iteration aborts with no done pulse
        issue(1'b0, 1'b0, 8'd200, 8'd3);
        step();
        step();
        step();
        rst = 1'b1;
        #1;
        check("abort busy", {31'h0, bus.busy}, 32'd0);
        check("abort done", {31'h0, bus.done}, 32'd0);
        check_res("abort", 8'h00, 8'h00, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.done === 1'b1) done_seen++;
        end
        check("abort no done", done_seen, 0);
        run_op("after reset 0F*0F", 1'b0, 1'b0, 8'h0F, 8'h0F, 8, 8'hE1, 8'h00, 1'b0, 1'b0);

`ifdef MULDIV_SIGNED_EN
        run_op("smul -7*3",   1'b0, 1'b1, 8'hF9, 8'h03, 8, 8'hEB, 8'hFF, 1'b0, 1'b0);
        run_op("sdiv -100/7", 1'b1, 1'b1, 8'h9C, 8'h07, 8, 8'hF2, 8'hFE, 1'b1, 1'b0);
        run_op("sdiv 80/FF",  1'b1, 1'b1, 8'h80, 8'hFF, 8, 8'h80, 8'h00, 1'b1, 1'b0);
        run_op("sdiv 85/0",   1'b1, 1'b1, 8'h85, 8'h00, 0, 8'hFF, 8'h85, 1'b1, 1'b1);
`else
        run_op("sgn ignored F9*3", 1'b0, 1'b1, 8'hF9, 8'h03, 8, 8'hEB, 8'h02, 1'b1, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
